mem_unit: RTL and testbench
===========================

MEM_UNIT -- requirements
Module: mem_unit

Interface
REQ-001 Parameter ADDR_W, default 9, SHALL set the word-address width (2^ADDR_W 32-bit words).
REQ-002 Parameter WAIT_CYCLES, default 2, SHALL set the wait states inserted per access (legal 0..15).
REQ-003 clk  input  1  single clock; all state changes on posedge.
REQ-004 clr  input  1  reset, asynchronous, active-low.
REQ-005 addr  input  32  word address from MAR; only addr[ADDR_W-1:0] used.
REQ-006 wData  input  32  write data from MDR output q.
REQ-007 read  input  1  read request, level, sampled only in IDLE.
REQ-008 write  input  1  write request, level, sampled only in IDLE.
REQ-009 mDataIn  output  32  registered read data to the MDR memory-side input.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  one-cycle pulse on rejected request.

Function
REQ-013 FSM SHALL have states IDLE, WAIT, DONE.
REQ-014 In IDLE, read XOR write high at posedge SHALL latch addr[ADDR_W-1:0], wData and op, and go to WAIT with counter = WAIT_CYCLES, or directly to DONE when WAIT_CYCLES = 0.
REQ-015 In IDLE, read AND write both high SHALL cause no access, stay in IDLE, and pulse err for the next cycle.
REQ-016 In WAIT, the counter SHALL decrement each cycle; on the edge where the counter equals 1, the FSM SHALL perform the access and enter DONE.
REQ-017 Latency: for a request sampled at edge N, done SHALL be high for exactly the cycle following edge N+WAIT_CYCLES+1.
REQ-018 Write SHALL update the array at the DONE-entry edge; mDataIn SHALL be unchanged by writes.
REQ-019 Read SHALL load mDataIn from the array at the DONE-entry edge; mDataIn SHALL hold that value until the next read completes.
REQ-020 DONE SHALL last one cycle, then return to IDLE unconditionally.
REQ-021 read and write SHALL be ignored in WAIT and DONE; the latched address and data SHALL not change mid-access.
REQ-022 A request still held high on return to IDLE SHALL start a new access; the requester drops read/write on seeing done.
REQ-023 Address bits above ADDR_W-1 SHALL be ignored, so address 2^ADDR_W aliases address 0.
REQ-024 A read of an address written by the immediately preceding access SHALL return the new data.
REQ-025 busy SHALL be combinational from state; done and err SHALL be registered.

Reset
REQ-026 clr low SHALL immediately force state IDLE, counter 0, mDataIn 0, busy 0, done 0 and err 0.
REQ-027 Assertion of clr mid-access SHALL abort the access, and a pending write SHALL not modify the array.
REQ-028 Array contents SHALL not be cleared by reset and are undefined until written.
REQ-029 The first request SHALL be sampled at the first posedge after clr deasserts.

Verification
REQ-030 The bench SHALL check: write 0xDEADBEEF to addr 0x5 with WAIT_CYCLES=2, then read 0x5 -> done exactly 3 cycles after each request edge, mDataIn = 0xDEADBEEF, busy high for 3 cycles.
REQ-031 The bench SHALL check: write 0x12345678 to addr 0x200 (ADDR_W=9), then read addr 0x0 -> mDataIn = 0x12345678 (aliasing).
REQ-032 The bench SHALL check: read and write high together in IDLE -> err pulse for 1 cycle, busy stays 0, no array or mDataIn change.
REQ-033 The bench SHALL check: write 0xAAAA5555 to addr 0x7, with clr pulsed low during WAIT -> outputs 0 at once, and a later read of 0x7 returns its prior value, not 0xAAAA5555.
REQ-034 The bench SHALL check: WAIT_CYCLES=0 with read held high for 4 cycles -> done pulses every 2 cycles, and read/write changes during WAIT/DONE have no effect.

Source files
------------

// File: rtl/mem_unit.sv
// Wait-stated 32-bit word memory: one access per request, done/err pulses one cycle after completion.
// Latency WAIT_CYCLES+1 edges to done; requests are ignored while busy (no queueing).
module mem_unit #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] addr,
  input  logic [31:0] wData,
  input  logic        read,
  input  logic        write,
  output logic [31:0] mDataIn,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdat;
  logic              r_wr;
  logic [31:0]       r_mem [0:(1<<ADDR_W)-1];

  logic              w_start;
  logic              w_conflict;
  logic              w_access;
  logic              w_acc_wr;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [31:0]       w_acc_dat;
  logic              w_unused_addr;

  assign w_unused_addr = ^addr[31:ADDR_W];

  assign w_start    = (r_state == S_IDLE) && (read ^ write);
  assign w_conflict = (r_state == S_IDLE) && read && write;

  // With zero wait states the access fires on the sampling edge, so use the live request
  assign w_access   = (WAIT_CYCLES == 0) ? w_start : ((r_state == S_WAIT) && (r_cnt <= 4'd1));
  assign w_acc_wr   = (r_state == S_IDLE) ? write : r_wr;
  assign w_acc_addr = (r_state == S_IDLE) ? addr[ADDR_W-1:0] : r_addr;
  assign w_acc_dat  = (r_state == S_IDLE) ? wData : r_wdat;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
      S_WAIT:  if (r_cnt <= 4'd1) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdat  <= 32'd0;
      r_wr    <= 1'b0;
      mDataIn <= 32'd0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= (r_state == S_DONE);
      err  <= w_conflict;
      if (w_start) begin
        r_cnt  <= LP_WAIT;
        r_addr <= addr[ADDR_W-1:0];
        r_wdat <= wData;
        r_wr   <= write;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access && !w_acc_wr) begin
        mDataIn <= r_mem[w_acc_addr];
      end
    end
  end

  // Array is not reset; an aborted access never reaches w_access because reset parks the FSM in IDLE
  always_ff @(posedge clk) begin
    if (w_access && w_acc_wr) begin
      r_mem[w_acc_addr] <= w_acc_dat;
    end
  end

endmodule

// File: tb/tb_mem_unit.sv
// Bench for mem_unit: vector table, hand-written corner sequences, then random traffic against an array model.
module tb_mem_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] addr, wData, q;
  logic        read, write, busy, done, err;
  logic [31:0] addr0, wd0, q0;
  logic        rd0, wr0, busy0, done0, err0;

  always #5 clk = ~clk;

  mem_unit #(.ADDR_W(9), .WAIT_CYCLES(2)) dut (
    .clk(clk), .clr(clr), .addr(addr), .wData(wData), .read(read), .write(write),
    .mDataIn(q), .busy(busy), .done(done), .err(err)
  );

  mem_unit #(.ADDR_W(9), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .clr(clr), .addr(addr0), .wData(wd0), .read(rd0), .write(wr0),
    .mDataIn(q0), .busy(busy0), .done(done0), .err(err0)
  );

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_q;
  } vec_t;

  vec_t        vecs [8];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] m_mem [512];
  logic [31:0] m_q;
  int          lat, bcnt;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic model_apply(input bit wr, input logic [31:0] a, input logic [31:0] d);
    logic [8:0] idx;
    idx = a[8:0];
    if (wr) m_mem[idx] = d;
    else    m_q = m_mem[idx];
  endtask

  // Drives one request and measures edges until done; optional junk on the inputs while busy
  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input bit scribble, output int l, output int bc);
    read = !wr; write = wr; addr = a; wData = d;
    @(posedge clk); #1;
    bc = int'(busy);
    l  = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (done) begin
        l = e;
        break;
      end
      bc += int'(busy);
      if (scribble) begin
        read  = 1'($urandom_range(0, 1));
        write = 1'($urandom_range(0, 1));
        addr  = $urandom;
        wData = $urandom;
      end
    end
    read = 1'b0; write = 1'b0;
  endtask

  initial begin
    clr = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wData = '0;
    rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wd0 = '0; m_q = '0;

    vecs[0] = '{1'b1, 32'h0000_0005, 32'hDEADBEEF, 32'h0000_0000};
    vecs[1] = '{1'b0, 32'h0000_0005, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 32'h0000_0200, 32'h12345678, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 32'h0000_0000, 32'h0,        32'h12345678};
    vecs[4] = '{1'b1, 32'h0000_0007, 32'h11112222, 32'h12345678};
    vecs[5] = '{1'b0, 32'hFFFF_FE07, 32'h0,        32'h11112222};
    vecs[6] = '{1'b1, 32'h0000_01FF, 32'hCAFEF00D, 32'h11112222};
    vecs[7] = '{1'b0, 32'h0000_03FF, 32'h0,        32'hCAFEF00D};

    repeat (2) @(posedge clk);
    #1;
    check("rst_q",    q,            32'h0);
    check("rst_busy", 32'(busy),    32'h0);
    check("rst_done", 32'(done),    32'h0);
    check("rst_err",  32'(err),     32'h0);
    check("rst_q0",   q0,           32'h0);
    clr = 1'b1;

    for (int i = 0; i < 8; i++) begin
      access(vecs[i].wr, vecs[i].a, vecs[i].d, (i % 2) == 1, lat, bcnt);
      model_apply(vecs[i].wr, vecs[i].a, vecs[i].d);
      check($sformatf("vec%0d_lat", i),  32'(lat),  32'd3);
      check($sformatf("vec%0d_busy", i), 32'(bcnt), 32'd3);
      check($sformatf("vec%0d_q", i),    q,         vecs[i].exp_q);
    end
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'h0);

    // read and write together: rejected, err for one cycle only
    read = 1'b1; write = 1'b1; addr = 32'h5; wData = 32'h0;
    @(posedge clk); #1;
    check("conf_err",  32'(err),  32'h1);
    check("conf_busy", 32'(busy), 32'h0);
    read = 1'b0; write = 1'b0;
    @(posedge clk); #1;
    check("conf_err_drop", 32'(err),  32'h0);
    check("conf_busy2",    32'(busy), 32'h0);
    check("conf_q",        q,         m_q);
    access(1'b0, 32'h5, 32'h0, 1'b0, lat, bcnt);
    model_apply(1'b0, 32'h5, 32'h0);
    check("conf_mem", q, 32'hDEADBEEF);

    // reset during WAIT aborts a pending write
    write = 1'b1; addr = 32'h7; wData = 32'hAAAA5555;
    @(posedge clk); #1;
    write = 1'b0;
    check("abort_busy_pre", 32'(busy), 32'h1);
    #2 clr = 1'b0;
    #1;
    check("abort_q",    q,          32'h0);
    check("abort_busy", 32'(busy),  32'h0);
    check("abort_done", 32'(done),  32'h0);
    check("abort_err",  32'(err),   32'h0);
    m_q = 32'h0;
    @(posedge clk); #1;
    clr = 1'b1;
    access(1'b0, 32'h7, 32'h0, 1'b0, lat, bcnt);
    model_apply(1'b0, 32'h7, 32'h0);
    check("abort_lat", 32'(lat), 32'd3);
    check("abort_mem", q,        32'h11112222);

    // zero wait states: held read completes every second cycle, DONE-time changes ignored
    wr0 = 1'b1; addr0 = 32'h3; wd0 = 32'h0BADF00D;
    @(posedge clk); #1;
    check("w0_wr_busy", 32'(busy0), 32'h1);
    check("w0_wr_done", 32'(done0), 32'h0);
    wr0 = 1'b0;
    @(posedge clk); #1;
    check("w0_wr_done2", 32'(done0), 32'h1);
    check("w0_wr_q",     q0,         32'h0);
    rd0 = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      check($sformatf("w0_done_e%0d", e), 32'(done0), (e % 2 == 0) ? 32'h1 : 32'h0);
      check($sformatf("w0_busy_e%0d", e), 32'(busy0), (e % 2 == 1) ? 32'h1 : 32'h0);
      check($sformatf("w0_q_e%0d", e),    q0,         32'h0BADF00D);
      if (e >= 2) check($sformatf("w0_err_e%0d", e), 32'(err0), 32'h0);
      if (e % 2 == 1) begin
        wr0 = 1'b1; addr0 = 32'h9; wd0 = 32'h0;
      end else begin
        wr0 = 1'b0; addr0 = 32'h3;
      end
    end
    rd0 = 1'b0; wr0 = 1'b0;

    // random traffic over a small address window, aliased through the upper bits
    for (int k = 0; k < 16; k++) begin
      logic [31:0] a, d;
      a = ($urandom & 32'hFFFF_FE00) | 32'(k);
      d = $urandom;
      access(1'b1, a, d, 1'b1, lat, bcnt);
      model_apply(1'b1, a, d);
    end
    for (int k = 0; k < 30; k++) begin
      bit          wr;
      logic [31:0] a, d;
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom & 32'hFFFF_FE00) | 32'($urandom_range(0, 15));
      d  = $urandom;
      access(wr, a, d, 1'($urandom_range(0, 1)), lat, bcnt);
      model_apply(wr, a, d);
      check($sformatf("rnd%0d_lat", k), 32'(lat), 32'd3);
      check($sformatf("rnd%0d_q", k),   q,        m_q);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
